// File: rtl/ej32_div.sv
// rtl/ej32_div.sv - signed restoring divider (idiv/irem) with divide-by-zero flag
module ej32_div #(
  parameter int DSZ = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [DSZ-1:0] x,
  input  logic [DSZ-1:0] y,
  output logic           bsy,
  output logic           done,
  output logic [DSZ-1:0] q,
  output logic [DSZ-1:0] r,
  output logic           dz
);

  localparam int CW = (DSZ > 1) ? $clog2(DSZ) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DSZ-1:0] rem_q, rem_d;
  logic [DSZ-1:0] quo_q, quo_d;
  logic [DSZ-1:0] dvs_q, dvs_d;
  logic           negq_q, negq_d;
  logic           negr_q, negr_d;
  logic           zdiv_q, zdiv_d;
  logic [DSZ-1:0] qo_q, qo_d;
  logic [DSZ-1:0] ro_q, ro_d;
  logic           dz_q, dz_d;
  logic           done_q, done_d;

  logic [DSZ:0]   rem_sh;
  logic [DSZ:0]   trial;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    zdiv_d  = zdiv_q;
    qo_d    = qo_q;
    ro_d    = ro_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    // quo_q doubles as the dividend shift register: its MSB feeds the remainder
    rem_sh  = {rem_q, quo_q[DSZ-1]};
    trial   = rem_sh - {1'b0, dvs_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          negr_d = x[DSZ-1];
          negq_d = x[DSZ-1] ^ y[DSZ-1];
          rem_d  = '0;
          if (y == '0) begin
            quo_d   = x;
            zdiv_d  = 1'b1;
            state_d = FIX;
          end else begin
            quo_d   = x[DSZ-1] ? -x : x;
            dvs_d   = y[DSZ-1] ? -y : y;
            zdiv_d  = 1'b0;
            cnt_d   = CW'(DSZ - 1);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (!trial[DSZ]) begin
          rem_d = trial[DSZ-1:0];
          quo_d = {quo_q[DSZ-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[DSZ-1:0];
          quo_d = {quo_q[DSZ-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FIX: begin
        if (zdiv_q) begin
          qo_d = '1;
          ro_d = quo_q;
          dz_d = 1'b1;
        end else begin
          qo_d = negq_q ? -quo_q : quo_q;
          ro_d = negr_q ? -rem_q : rem_q;
          dz_d = 1'b0;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      zdiv_q  <= 1'b0;
      qo_q    <= '0;
      ro_q    <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      zdiv_q  <= zdiv_d;
      qo_q    <= qo_d;
      ro_q    <= ro_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign bsy  = (state_q != IDLE);
  assign done = done_q;
  assign q    = qo_q;
  assign r    = ro_q;
  assign dz   = dz_q;

endmodule

// File: doc/ej32_div.md
EJ32_DIV -- requirements
Module: ej32_div

Interface
REQ-001 SHALL have parameter DSZ, default 32, data width of operands and results.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  request a division; sampled only when idle.
REQ-005 SHALL have port x  input  DSZ  dividend (NOS), signed two's complement.
REQ-006 SHALL have port y  input  DSZ  divisor (TOS), signed two's complement.
REQ-007 SHALL have port bsy  output  1  division in progress; drives the arithmetic unit's div_bsy.
REQ-008 SHALL have port done  output  1  one-cycle pulse, results valid.
REQ-009 SHALL have port q  output  DSZ  quotient (idiv result).
REQ-010 SHALL have port r  output  DSZ  remainder (irem result).
REQ-011 SHALL have port dz  output  1  divide-by-zero flag of last completed operation.

Function
REQ-012 SHALL implement states IDLE, CALC, FIX; bsy = (state != IDLE), decoded from registered state only.
REQ-013 In IDLE with start=1 and y!=0: SHALL latch |x|, |y|, sign of x, sign of x XOR sign of y; clear partial remainder; load iteration counter with DSZ-1; go to CALC.
REQ-014 In IDLE with start=1 and y==0: SHALL latch x, set a zero-divisor marker, go directly to FIX.
REQ-015 CALC SHALL perform one unsigned restoring-division step per cycle: shift remainder/dividend left by 1, subtract |y| when remainder >= |y|, shift quotient bit in.
REQ-016 CALC SHALL last exactly DSZ cycles; at counter==0 go to FIX; counter decrements by 1 per cycle without wrap.
REQ-017 FIX SHALL negate quotient when signs differ and negate remainder when x was negative, write q and r, pulse done for the following cycle, return to IDLE.
REQ-018 Latency: start accepted at edge N -> bsy=1 from edge N to edge N+DSZ+1 (DSZ+1 cycles), done=1 and q/r valid from edge N+DSZ+1 for exactly one cycle.
REQ-019 Divide-by-zero: bsy=1 for exactly 1 cycle; then q=all ones, r=x, dz=1, done pulses.
REQ-020 Overflow x=most-negative, y=-1: q SHALL equal x (most-negative), r=0, dz=0 (Java semantics, no trap).
REQ-021 Rounding: quotient truncates toward zero; remainder takes sign of dividend; x == q*y + r always holds modulo 2^DSZ for y!=0.
REQ-022 start while bsy=1 SHALL be ignored; operands x/y SHALL NOT be re-sampled during CALC/FIX.
REQ-023 q, r, dz SHALL hold their last values in IDLE until the next completion; dz updates only at completion.
REQ-024 start in the same cycle done is high SHALL be accepted (back-to-back operation, no dead cycle).
REQ-025 Block SHALL contain no combinational path from start/x/y to any output.

Reset
REQ-026 rst=0 at a rising edge SHALL force state=IDLE, bsy=0, done=0, q=0, r=0, dz=0, counter=0.
REQ-027 Reset mid-operation (CALC or FIX) SHALL abort it with no done pulse and no q/r update other than clearing.
REQ-028 start asserted in the cycle rst=0 SHALL be ignored.

Verification
REQ-029 x=100, y=7, start one cycle -> bsy high 33 cycles, then done one cycle, q=14, r=2, dz=0.
REQ-030 x=-7, y=2 -> q=32'hFFFFFFFD (-3), r=32'hFFFFFFFF (-1); x=7, y=-2 -> q=-3, r=1.
REQ-031 x=32'h80000000, y=32'hFFFFFFFF -> q=32'h80000000, r=0, dz=0, latency 33 cycles.
REQ-032 x=5, y=0 -> bsy high 1 cycle, then done, q=32'hFFFFFFFF, r=5, dz=1; next x=9, y=3 -> q=3, r=0, dz=0.
REQ-033 Start x=100, y=7; re-assert start with x=1, y=1 at cycle 5 -> ignored, result q=14, r=2; start again in the done cycle -> accepted, q=1, r=0 after 33 more cycles.
REQ-034 Start x=100, y=7; rst=0 at CALC cycle 10 -> next cycle bsy=0, q=0, r=0, no done pulse for 40 cycles.
